// File: rtl/pipe_pkg.sv
// pipe_pkg: default EX/MEM widths and the EX/MEM payload layout
package pipe_pkg;
    localparam int DEF_PC_WIDTH     = 64;
    localparam int DEF_REG_WIDTH    = 64;
    localparam int DEF_REG_COUNT    = 32;
    localparam int DEF_AW           = $clog2(DEF_REG_COUNT);
    localparam int DEF_M_CTRL_BITS  = 5;
    localparam int DEF_WB_CTRL_BITS = 5;

    typedef struct packed {
        logic [DEF_WB_CTRL_BITS-1:0] wb_ctrl;
        logic [DEF_M_CTRL_BITS-1:0]  m_ctrl;
        logic [DEF_PC_WIDTH-1:0]     pc;
        logic [DEF_REG_WIDTH-1:0]    alu_res;
        logic [DEF_REG_WIDTH-1:0]    rs2_data;
        logic [DEF_AW-1:0]           rd_addr;
        logic [DEF_AW-1:0]           rs2_addr;
    } ex_mem_payload_t;
endpackage

// File: rtl/stage_slot.sv
// stage_slot: payload register with valid flag; ports clk, rst (async), load, clear (wins over load), d -> valid, q
module stage_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear)
            valid <= 1'b0;
        else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with a two-slot skid buffer; ports: in_valid/in_ready + payload in,
// out_valid/out_ready + payload out, flush, occupancy (held beats)
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int PC_WIDTH     = pipe_pkg::DEF_PC_WIDTH,
    parameter int REG_WIDTH    = pipe_pkg::DEF_REG_WIDTH,
    parameter int REG_COUNT    = pipe_pkg::DEF_REG_COUNT,
    parameter int M_CTRL_BITS  = pipe_pkg::DEF_M_CTRL_BITS,
    parameter int WB_CTRL_BITS = pipe_pkg::DEF_WB_CTRL_BITS,
    localparam int AW          = $clog2(REG_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    input  logic [WB_CTRL_BITS-1:0] wb_ctrl_in,
    input  logic [M_CTRL_BITS-1:0]  m_ctrl_in,
    input  logic [PC_WIDTH-1:0]     pc_in,
    input  logic [REG_WIDTH-1:0]    alu_res_in,
    input  logic [REG_WIDTH-1:0]    rs2_data_in,
    input  logic [AW-1:0]           rd_addr_in,
    input  logic [AW-1:0]           rs2_addr_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WB_CTRL_BITS-1:0] wb_ctrl_out,
    output logic [M_CTRL_BITS-1:0]  m_ctrl_out,
    output logic [PC_WIDTH-1:0]     pc_out,
    output logic [REG_WIDTH-1:0]    alu_res_out,
    output logic [REG_WIDTH-1:0]    rs2_data_out,
    output logic [AW-1:0]           rd_addr_out,
    output logic [AW-1:0]           rs2_addr_out,
    output logic [1:0]              occupancy
);
    localparam int PW = WB_CTRL_BITS + M_CTRL_BITS + PC_WIDTH + 2 * REG_WIDTH + 2 * AW;

    logic [PW-1:0] in_bus, main_q, skid_q;
    logic [WB_CTRL_BITS-1:0] wb_q;
    logic [M_CTRL_BITS-1:0] m_q;
    logic main_v, skid_v, accept, drain, main_load, main_clear, skid_load, skid_clear;

    assign in_bus = {wb_ctrl_in, m_ctrl_in, pc_in, alu_res_in, rs2_data_in, rd_addr_in, rs2_addr_in};
    assign drain  = main_v & out_ready;
    assign accept = in_valid & ~skid_v & ~flush;
    // in_ready is low whenever SKID is full, so MAIN is refilled either from SKID or from the input, never both
    assign main_load  = (accept & (~main_v | drain)) | (drain & skid_v);
    assign main_clear = flush | (drain & ~main_load);
    assign skid_load  = accept & main_v & ~drain;
    assign skid_clear = flush | (drain & skid_v);

    stage_slot #(.W(PW)) u_main (
        .clk(clk), .rst(rst), .load(main_load), .clear(main_clear),
        .d(skid_v ? skid_q : in_bus), .valid(main_v), .q(main_q)
    );

    stage_slot #(.W(PW)) u_skid (
        .clk(clk), .rst(rst), .load(skid_load), .clear(skid_clear),
        .d(in_bus), .valid(skid_v), .q(skid_q)
    );

    assign {wb_q, m_q, pc_out, alu_res_out, rs2_data_out, rd_addr_out, rs2_addr_out} = main_q;
    // control fields are forced to a bubble whenever nothing valid is presented
    assign wb_ctrl_out = main_v ? wb_q : '0;
    assign m_ctrl_out  = main_v ? m_q : '0;
    assign out_valid   = main_v;
    assign in_ready    = ~skid_v;
    assign occupancy   = {1'b0, main_v} + {1'b0, skid_v};
endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- PC_WIDTH, 64, program-counter width
- REG_WIDTH, 64, data-path width
- REG_COUNT, 32, register-file entries; AW = $clog2(REG_COUNT)
- M_CTRL_BITS, 5, MEM control width
- WB_CTRL_BITS, 5, WB control width

REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  EX offers a beat
- in_ready  out  1  stage can accept a beat
- flush  in  1  kill all held and incoming beats
- wb_ctrl_in  in  WB_CTRL_BITS  WB control
- m_ctrl_in  in  M_CTRL_BITS  MEM control
- pc_in  in  PC_WIDTH  instruction PC
- alu_res_in  in  REG_WIDTH  ALU result
- rs2_data_in  in  REG_WIDTH  store data
- rd_addr_in  in  AW  destination register
- rs2_addr_in  in  AW  rs2 index, for forwarding
- out_valid  out  1  beat presented to MEM
- out_ready  in  1  MEM accepts the beat
- wb_ctrl_out, m_ctrl_out, pc_out, alu_res_out, rs2_data_out, rd_addr_out, rs2_addr_out  out  matching widths  presented beat
- occupancy  out  2  held beats, 0..2

Function
REQ-003 SHALL hold two slots: MAIN, which drives the outputs, and SKID; beats SHALL leave in strict arrival order.
REQ-004 in_ready SHALL equal !SKID.valid and SHALL be a registered function of state only, with no combinational path from out_ready.
REQ-005 Accept = in_valid && in_ready && !flush; drain = out_valid && out_ready.
REQ-006 On accept, the beat SHALL enter MAIN if MAIN is empty or draining this cycle, otherwise SKID.
REQ-007 On drain with SKID full, SKID SHALL move to MAIN next cycle, and any accepted beat is impossible in that cycle because in_ready=0.
REQ-008 Latency SHALL be 1 cycle: a beat accepted at edge N is presented with out_valid=1 after edge N.
REQ-009 With out_ready held at 1, the stage SHALL sustain one beat per cycle with occupancy at most 1.
REQ-010 While out_valid && !out_ready && !flush, all outputs SHALL be stable.
REQ-011 Whenever out_valid=0, wb_ctrl_out and m_ctrl_out SHALL be 0 (bubble); data fields MAY hold stale values.
REQ-012 flush SHALL invalidate MAIN and SKID at the next edge and drop any incoming beat; flush SHALL dominate a simultaneous accept. A drain in the flush cycle SHALL count as consumed.
REQ-013 occupancy SHALL equal MAIN.valid + SKID.valid.
REQ-014 Field widths SHALL pass through unchanged, with no truncation or extension.

Reset
REQ-015 On rst, both slots SHALL be invalid immediately, with no clock required.
REQ-016 During and after rst, every payload output SHALL be 0, out_valid=0, occupancy=0, and in_ready=1 on the first edge after deassertion.
REQ-017 Reset asserted mid-transfer SHALL discard all beats, and no partial beat SHALL appear after release.

Structure
REQ-018 A shared package pipe_pkg SHALL hold the default width constants and a packed struct ex_mem_payload_t containing the seven fields in port order.
REQ-019 One sub-module, stage_slot, SHALL be a payload register with valid, load and clear; it SHALL be instantiated twice, as MAIN and SKID.
REQ-020 Implementation SHALL be 120-400 lines of RTL.

Verification
REQ-021 Reset: assert rst mid-stream with 2 beats held -> out_valid=0, occupancy=0, and all outputs 0 within the same cycle.
REQ-022 Streaming: 8 beats with pc 0x100..0x11C, in_valid=1, out_ready=1 -> pc_out sequence identical, one per cycle, 1-cycle latency, occupancy<=1.
REQ-023 Backpressure: out_ready=0 while beats A (pc=0x200) and B (pc=0x204) arrive -> occupancy=2, in_ready=0, pc_out=0x200 stable. After out_ready=1, outputs are A then B with no loss.
REQ-024 Flush: occupancy=2 and in_valid=1 with flush=1 -> next cycle occupancy=0, out_valid=0, wb_ctrl_out=0, m_ctrl_out=0, and the incoming beat is never output.
REQ-025 Bubble: in_valid=0 for 3 cycles between beats -> out_valid=0 with ctrl outputs 0 exactly in those cycles.
REQ-026 Random valid/ready for 10k cycles against a FIFO model -> ordered and lossless, and in_ready never depends combinationally on out_ready.
